// File: rtl/branch_cond_unit.sv
// branch_cond_unit: evaluates MIPS branch/register-jump conditions with operand-wait FSM.
// Optional macro BRANCH_STATS_EN adds saturating branch/taken counters.
module branch_cond_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [5:0]            Opcode,
    input  logic [4:0]            Rt,
    input  logic [5:0]            Funct,
    input  logic                  RType,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  A_Ready,
    input  logic                  B_Ready,
    input  logic                  Flush,
    output logic                  Out_Valid,
    output logic                  Taken,
    output logic                  IsBranch,
    output logic                  IsJumpReg,
    output logic                  Stall,
    output logic [CNT_WIDTH-1:0]  BranchCount,
    output logic [CNT_WIDTH-1:0]  TakenCount
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, nxt;
    logic [5:0] op_q, funct_q, op, funct;
    logic [4:0] rt_q, rt;
    logic rtype_q, rtype;
    logic a_neg, a_zero, is_jr, is_regimm, is_beq, is_bne, is_bgtz, is_blez;
    logic is_br, need_b, cond, opnd_ok, accept;
    logic taken_q, br_q, jr_q;

    // While waiting, decode from the latched instruction; operands stay live.
    assign op    = (state == WAIT) ? op_q    : Opcode;
    assign rt    = (state == WAIT) ? rt_q    : Rt;
    assign funct = (state == WAIT) ? funct_q : Funct;
    assign rtype = (state == WAIT) ? rtype_q : RType;

    assign a_neg     = A[DATA_WIDTH-1];
    assign a_zero    = (A == '0);
    assign is_jr     = rtype & ((funct == 6'b001000) | (funct == 6'b001001));
    assign is_regimm = ~rtype & (op == 6'b000001) & ((rt == 5'd0) | (rt == 5'd1));
    assign is_beq    = ~rtype & (op == 6'b000100);
    assign is_bne    = ~rtype & (op == 6'b000101);
    assign is_bgtz   = ~rtype & (op == 6'b000111);
    assign is_blez   = ~rtype & (op == 6'b000110);
    assign is_br     = is_jr | is_regimm | is_beq | is_bne | is_bgtz | is_blez;
    assign need_b    = is_beq | is_bne;

    // Signed tests against zero reduce to the sign bit and a zero detect.
    assign cond = is_jr
                | (is_regimm & (rt[0] ? ~a_neg : a_neg))
                | (is_beq & (A == B))
                | (is_bne & (A != B))
                | (is_bgtz & ~a_neg & ~a_zero)
                | (is_blez & (a_neg | a_zero));

    assign opnd_ok  = ~is_br | (A_Ready & (~need_b | B_Ready));
    assign In_Ready = (state != WAIT);
    assign accept   = In_Valid & In_Ready & ~Flush;

    always_comb begin
        nxt = IDLE;
        if (Flush)
            nxt = IDLE;
        else if (state == WAIT)
            nxt = opnd_ok ? DONE : WAIT;
        else if (accept)
            nxt = opnd_ok ? DONE : WAIT;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            taken_q <= 1'b0;
            br_q    <= 1'b0;
            jr_q    <= 1'b0;
            op_q    <= '0;
            rt_q    <= '0;
            funct_q <= '0;
            rtype_q <= 1'b0;
        end else begin
            state   <= nxt;
            taken_q <= (nxt == DONE) & cond;
            br_q    <= (nxt == DONE) & is_br;
            jr_q    <= (nxt == DONE) & is_jr;
            if (accept) begin
                op_q    <= Opcode;
                rt_q    <= Rt;
                funct_q <= Funct;
                rtype_q <= RType;
            end
        end
    end

    assign Out_Valid = (state == DONE);
    assign Taken     = taken_q;
    assign IsBranch  = br_q;
    assign IsJumpReg = jr_q;
    assign Stall     = Rst_n & ((state == WAIT) | (accept & ~opnd_ok));

`ifdef BRANCH_STATS_EN
    logic [CNT_WIDTH-1:0] bcnt, tcnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bcnt <= '0;
            tcnt <= '0;
        end else begin
            if (Out_Valid & br_q & ~&bcnt)
                bcnt <= bcnt + 1'b1;
            if (Out_Valid & taken_q & ~&tcnt)
                tcnt <= tcnt + 1'b1;
        end
    end

    assign BranchCount = bcnt;
    assign TakenCount  = tcnt;
`else
    assign BranchCount = '0;
    assign TakenCount  = '0;
`endif
endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, operand width in bits (signed two's complement).
REQ-002 Parameter: CNT_WIDTH, 16, width of the statistics counters.
REQ-003 Port: Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: Rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: In_Valid  input  1  decoded instruction presented for evaluation.
REQ-006 Port: In_Ready  output  1  unit can accept an instruction this cycle.
REQ-007 Port: Opcode  input  6  instruction opcode.
REQ-008 Port: Rt  input  5  rt field; selects the REGIMM variant.
REQ-009 Port: Funct  input  6  funct field, used when RType=1.
REQ-010 Port: RType  input  1  instruction is R-type.
REQ-011 Port: A, B  input  DATA_WIDTH each  rs and rt operand values from the forwarding path.
REQ-012 Port: A_Ready, B_Ready  input  1 each  corresponding operand is current (no pending producer).
REQ-013 Port: Flush  input  1  discard any in-flight evaluation.
REQ-014 Port: Out_Valid  output  1  one-cycle pulse; result fields are valid.
REQ-015 Port: Taken  output  1  branch or jump is taken.
REQ-016 Port: IsBranch  output  1  instruction was a conditional branch or register jump.
REQ-017 Port: IsJumpReg  output  1  instruction was jr or jalr.
REQ-018 Port: Stall  output  1  upstream must hold; operands not yet available.
REQ-019 Port: BranchCount, TakenCount  output  CNT_WIDTH each  evaluated-branch and taken-branch counters.

Function
REQ-020 The unit SHALL decode as follows: Opcode 000001 with Rt=00001 is bgez (A>=0); Opcode 000001 with Rt=00000 is bltz (A<0); 000100 is beq (A==B); 000101 is bne (A!=B); 000111 is bgtz (A>0); 000110 is blez (A<=0); RType=1 with Funct 001000 is jr and Funct 001001 is jalr (always taken).
REQ-021 All comparisons SHALL be signed and use the full DATA_WIDTH.
REQ-022 beq and bne SHALL require both A_Ready and B_Ready; all other branches and jr/jalr SHALL require only A_Ready.
REQ-023 Any other instruction SHALL complete without waiting, with IsBranch=0, IsJumpReg=0 and Taken=0.
REQ-024 The FSM SHALL have three states: IDLE, WAIT, and DONE. In_Ready SHALL be 1 only in IDLE and DONE.
REQ-025 On an accept (In_Valid & In_Ready) with the required operands ready, the FSM SHALL go to DONE, and Out_Valid and its results SHALL register on that edge (latency 1 cycle).
REQ-026 On an accept with a required operand not ready, the FSM SHALL latch Opcode, Rt, Funct and RType, go to WAIT, and assert Stall.
REQ-027 In WAIT, the unit SHALL re-sample A and B every cycle, hold Stall=1, and on the first cycle the required operands are ready, evaluate and go to DONE with Out_Valid=1.
REQ-028 In DONE, Out_Valid SHALL be 1 for exactly that cycle. A simultaneous accept SHALL be handled as from IDLE (back-to-back throughput of 1 per cycle); otherwise the FSM SHALL return to IDLE.
REQ-029 Stall SHALL be combinationally 1 in the accept cycle when required operands are not ready, and 1 throughout WAIT.
REQ-030 Flush SHALL force the FSM to IDLE on the next edge, suppress Out_Valid for the flushed instruction, and take priority over In_Valid in the same cycle.
REQ-031 Outside Out_Valid cycles, Taken, IsBranch and IsJumpReg SHALL be 0.

Reset
REQ-032 When Rst_n=0, the unit SHALL asynchronously enter IDLE and drive Out_Valid, Taken, IsBranch, IsJumpReg and Stall to 0 and BranchCount and TakenCount to 0; In_Ready SHALL be 1 after reset.
REQ-033 Reset asserted during WAIT SHALL discard the latched instruction and produce no Out_Valid.

Configuration
REQ-034 With macro BRANCH_STATS_EN defined, BranchCount SHALL increment on each Out_Valid with IsBranch=1, and TakenCount SHALL increment on each Out_Valid with Taken=1; both SHALL saturate at all-ones.
REQ-035 Without BRANCH_STATS_EN, no counter logic SHALL be present, and both count outputs SHALL be constant 0.

Verification
REQ-036 beq with A=5, B=5, both ready -> next cycle Out_Valid=1, Taken=1, IsBranch=1, Stall never asserted.
REQ-037 Opcode 000001: Rt=00000 with A=-1 -> Taken=1 (bltz); Rt=00001 with A=-1 -> Taken=0 (bgez); Rt=00001 with A=0 -> Taken=1.
REQ-038 bne with B_Ready=0 for 3 cycles, then ready with A=1, B=2 -> Stall=1 for those cycles, Out_Valid=1 with Taken=1 one cycle after ready.
REQ-039 Flush asserted in WAIT -> no Out_Valid, In_Ready=1 next cycle; Rst_n pulsed low mid-WAIT -> all outputs 0 immediately.
REQ-040 Back-to-back: bgtz A=7, then blez A=7, then jr -> Out_Valid on 3 consecutive cycles with Taken=1,0,1 and IsJumpReg=0,0,1.
REQ-041 With BRANCH_STATS_EN and CNT_WIDTH=2, five taken branches -> BranchCount=TakenCount=3 (saturated); without the macro -> both 0.
